// File: rtl/alu_writeback.sv
// ALU writeback stage: a 2-entry result FIFO feeds a register-file write port and the HI/LO registers.
// Latency: a result reaches rf/hi/lo one edge after it is accepted; wide mul/div takes 2 write cycles. in_ready is low when the FIFO is full.

module alu_writeback_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clock) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rp];
endmodule

module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [CTL_W-1:0]    in_ctl,
  input  logic [REG_AW-1:0]   in_dest,
  input  logic                in_wide,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic                busy
);
  typedef struct packed {
    logic [2*DATA_W-1:0] result;
    logic [CTL_W-1:0]    ctl;
    logic [REG_AW-1:0]   dest;
    logic                wide;
  } entry_t;

  typedef enum logic {IDLE, WR_HI} state_t;

  state_t              state;
  entry_t              in_ent;
  entry_t              head;
  logic [1:0]          count;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   hold_data;
  logic [REG_AW-1:0]   hold_addr;

  assign in_ent   = '{result: in_result, ctl: in_ctl, dest: in_dest, wide: in_wide};
  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready = clear && (count < 2'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = clear && (state == IDLE) && (count != 2'd0);
  assign busy     = (count != 2'd0) || (state == WR_HI);

  alu_writeback_fifo #(.W($bits(entry_t))) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (in_ent),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      hi        <= '0;
      lo        <= '0;
      hold_data <= '0;
      hold_addr <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            case (head.ctl)
              CTL_W'(3), CTL_W'(4): begin
                hi <= head.result[2*DATA_W-1:DATA_W];
                lo <= head.result[DATA_W-1:0];
                if (head.wide) begin
                  rf_we     <= 1'b1;
                  rf_addr   <= head.dest;
                  rf_data   <= head.result[DATA_W-1:0];
                  hold_addr <= head.dest + REG_AW'(1);
                  hold_data <= head.result[2*DATA_W-1:DATA_W];
                  state     <= WR_HI;
                end
              end
              CTL_W'(1), CTL_W'(2), CTL_W'(5), CTL_W'(6), CTL_W'(7), CTL_W'(8),
              CTL_W'(9), CTL_W'(10), CTL_W'(11), CTL_W'(12): begin
                rf_we   <= 1'b1;
                rf_addr <= head.dest;
                rf_data <= head.result[DATA_W-1:0];
              end
              default: ;
            endcase
          end
        end
        WR_HI: begin
          rf_we   <= 1'b1;
          rf_addr <= hold_addr;
          rf_data <= hold_data;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
